spi_host_driver: RTL and testbench
==================================

# spi_host_driver

Synthesizable SPI controller that acts as the initiating end of the `spi_device` pin interface. It drives SCK/CSB/SDI and samples SDO, so it can exercise the on-chip SPI device in simulation tops and FPGA test harnesses in place of the SPI DPI model. Bytes arrive on a valid/ready command stream, and the bytes shifted in are returned on a valid/ready response stream. It supports SPI mode 0 only (CPOL=0, CPHA=0), MSB first, one data lane.

## Interface
- `ClkDiv`, default 4: `clk_i` cycles per SCK half-period; must be >= 1.
- `CsbSetup`, default 2: cycles with CSB low before the first SCK half-period; must be >= 1.
- `CsbHold`, default 2: cycles after the last SCK fall before CSB rises; must be >= 1.
- `CsbIdle`, default 4: minimum cycles CSB stays high between transactions; must be >= 1.

- `clk_i` input 1: single clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `tx_valid_i` input 1: command byte valid.
- `tx_ready_o` output 1: command byte accepted when high together with `tx_valid_i`.
- `tx_data_i` input 8: byte to shift out.
- `tx_last_i` input 1: this byte ends the transaction; CSB deasserts after it.
- `rx_valid_o` output 1: response byte valid.
- `rx_ready_i` input 1: response consumer ready.
- `rx_data_o` output 8: byte shifted in.
- `busy_o` output 1: high whenever the FSM is not in IDLE.
- `spi_device_sck_o` output 1: SPI clock.
- `spi_device_csb_o` output 1: chip select, active-low.
- `spi_device_sdi_o` output 1: data to device.
- `spi_device_sdo_i` input 1: data from device.
- `spi_device_sdo_en_i` input 1: device output enable; when low, the sampled bit is 1 (pull-up).

## Operation
- Reset values: `sck`=0, `csb`=1, `sdi`=0, `tx_ready_o`=0, `rx_valid_o`=0, `rx_data_o`=0, `busy_o`=0. FSM resets to IDLE.
- FSM states:
  - IDLE
  - SETUP
  - SHIFT
  - GAP: CSB low, waiting for the next byte.
  - HOLD
  - CSIDLE
- `tx_ready_o` is 1 only in IDLE or GAP and only while `rx_valid_o`=0. It is registered and has no combinational path from `rx_ready_i`.
- IDLE, on handshake: latch the byte and `tx_last_i`, then go to SETUP with `csb`=0 and `sdi`=bit7.
- SETUP: stay `CsbSetup` cycles, then go to SHIFT.
- SHIFT: 8 bits, each a low phase then a high phase, each phase `ClkDiv` cycles.
  - `sdi` changes only at the start of a low phase.
  - SDO is sampled in the last cycle of each high phase. Note this is the registered clock edge where `sck_o` falls; do not sample earlier.
- After bit 0's high phase, `sck` returns to 0, `rx_data_o` is loaded, and `rx_valid_o` is set.
  - If the latched last flag is 1, go to HOLD.
  - Otherwise go to GAP.
- GAP: CSB stays low and SCK stays low indefinitely. A handshake (possible once the response byte is consumed) goes directly to SHIFT with no SETUP.
- HOLD: stay `CsbHold` cycles, then set `csb`=1 and go to CSIDLE.
- CSIDLE: stay `CsbIdle` cycles, then go to IDLE.
- Response slot: one entry. `rx_valid_o` clears on `rx_valid_o && rx_ready_i`. Because `tx_ready_o` gates the next byte, the slot cannot overflow.
- Boundary cases:
  - A `tx_valid_i` that arrives during HOLD or CSIDLE is not accepted until IDLE.
  - Toggling `tx_data_i` while not accepted has no effect.
  - Reset during any state returns all outputs to their reset values immediately. No SCK edge is emitted and CSB rises asynchronously.
- Counters: the phase counter is `$clog2(max(ClkDiv,CsbSetup,CsbHold,CsbIdle))+1` bits wide and counts down to 0. The bit counter is 3 bits and wraps 0→7 per byte.

## Timing
- Handshake at cycle 0 from IDLE: CSB falls at cycle 1.
- First SCK rise: cycle 1+`CsbSetup`+`ClkDiv`.
- `rx_valid_o` asserts at cycle 1+`CsbSetup`+16·`ClkDiv`.
- GAP→SHIFT: the first SCK rise is `ClkDiv`+1 cycles after the handshake.
- Last byte: CSB rises `CsbHold` cycles after the last SCK fall. `tx_ready_o` returns `CsbIdle`+1 cycles after CSB rises.
- SCK period is exactly 2·`ClkDiv` cycles with 50% duty cycle.

## Structure
- Package `spi_host_driver_pkg`: the FSM state enum `spi_host_state_e` and the mode/bit-order localparams.
- Sub-module `spi_host_driver_phase_cnt`: a loadable down-counter with a `done` pulse, shared by SETUP, the SHIFT phases, HOLD and CSIDLE.
- Single top FSM containing the shift register, bit counter and response register.

## Test plan
- Reset with `ClkDiv`=2: outputs are `csb`=1, `sck`=0, `tx_ready_o`=0 during reset and `tx_ready_o`=1 one cycle after release. Assert `rst_ni` mid-SHIFT: CSB rises in the same cycle and no further SCK edges occur.
- Send 0xA5 with last=1 and a device echoing 0x3C: SDI bits 1,0,1,0,0,1,0,1 on 8 SCK rises; `rx_data_o`=0x3C; CSB low for `CsbSetup`+16·`ClkDiv`+`CsbHold` cycles.
- Send 3 bytes 0x9F,0x00,0x00 with last on byte 3: CSB stays low throughout, with exactly 24 SCK rises, and 3 responses in order.
- Hold `rx_ready_i`=0 after byte 1 of a 2-byte transfer: the FSM stays in GAP with CSB low and no SCK activity. Raising `rx_ready_i` resumes, and the second response is correct.
- `sdo_en_i`=0 for a whole byte: `rx_data_o`=0xFF.
- Back-to-back single-byte transactions: CSB high for at least `CsbIdle` cycles between them, and `busy_o` drops for at least 1 cycle.

Source files
------------

// File: rtl/spi_host_driver_pkg.sv
// Shared types for the SPI host driver: FSM states, mode constants
// and the phase-counter width helper.
package spi_host_driver_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StGap,
    StHold,
    StCsIdle
  } spi_host_state_e;

  // Mode 0 only, MSB first, single lane.
  localparam logic Cpol     = 1'b0;
  localparam logic Cpha     = 1'b0;
  localparam logic MsbFirst = 1'b1;

  localparam int unsigned BitCntW = 3;

  // Wide enough to hold (max timing parameter - 1) with headroom.
  function automatic int unsigned phase_cnt_w(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c,
    input int unsigned d
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/spi_host_driver_phase_cnt.sv
// Loadable down-counter; done_o is high while the count sits at zero.
// Ports: clk_i, rst_ni, load_i, load_val_i, done_o.
module spi_host_driver_phase_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/spi_host_driver.sv
// SPI mode-0 host: bytes in on tx stream, shifted-in bytes out on rx.
// Ports: tx/rx valid-ready streams, busy_o, spi_device_* pins.
module spi_host_driver
  import spi_host_driver_pkg::*;
#(
  parameter int unsigned ClkDiv   = 4,
  parameter int unsigned CsbSetup = 2,
  parameter int unsigned CsbHold  = 2,
  parameter int unsigned CsbIdle  = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_last_i,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic [7:0] rx_data_o,
  output logic       busy_o,
  output logic       spi_device_sck_o,
  output logic       spi_device_csb_o,
  output logic       spi_device_sdi_o,
  input  logic       spi_device_sdo_i,
  input  logic       spi_device_sdo_en_i
);

  localparam int unsigned CntW =
    phase_cnt_w(ClkDiv, CsbSetup, CsbHold, CsbIdle);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t DivLd   = cnt_t'(ClkDiv - 1);
  localparam cnt_t SetupLd = cnt_t'(CsbSetup - 1);
  localparam cnt_t HoldLd  = cnt_t'(CsbHold - 1);
  localparam cnt_t IdleLd  = cnt_t'(CsbIdle - 1);

  spi_host_state_e state_q, state_d;

  logic               sck_q, sck_d;
  logic               csb_q, csb_d;
  logic               sdi_q, sdi_d;
  logic [7:0]         sreg_q, sreg_d;
  logic [BitCntW-1:0] bit_q, bit_d;
  logic               last_q, last_d;
  logic               rx_valid_q, rx_valid_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               tx_ready_q, tx_ready_d;

  logic cnt_load;
  cnt_t cnt_val;
  logic cnt_done;

  logic hs;
  logic sdo_bit;
  logic sample;
  logic byte_end;

  spi_host_driver_phase_cnt #(
    .Width(CntW)
  ) u_phase_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .done_o    (cnt_done)
  );

  assign hs      = tx_valid_i & tx_ready_q;
  // Released SDO line reads as 1.
  assign sdo_bit = spi_device_sdo_en_i ? spi_device_sdo_i : 1'b1;
  // Sample on the cycle that ends a high phase (SCK falls next).
  assign sample   = (state_q == StShift) & cnt_done & sck_q;
  assign byte_end = sample & (bit_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      sck_q      <= Cpol;
      csb_q      <= 1'b1;
      sdi_q      <= 1'b0;
      sreg_q     <= '0;
      bit_q      <= '1;
      last_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      tx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_q      <= sck_d;
      csb_q      <= csb_d;
      sdi_q      <= sdi_d;
      sreg_q     <= sreg_d;
      bit_q      <= bit_d;
      last_q     <= last_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (hs) state_d = StSetup;
      StSetup:  if (cnt_done) state_d = StShift;
      StShift: begin
        if (byte_end) state_d = last_q ? StHold : StGap;
      end
      StGap:    if (hs) state_d = StShift;
      StHold:   if (cnt_done) state_d = StCsIdle;
      StCsIdle: if (cnt_done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    sck_d     = sck_q;
    csb_d     = csb_q;
    sdi_d     = sdi_q;
    sreg_d    = sreg_q;
    bit_d     = bit_q;
    last_d    = last_q;
    rx_data_d = rx_data_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;

    unique case (state_q)
      StIdle, StGap: begin
        if (hs) begin
          sreg_d   = tx_data_i;
          sdi_d    = tx_data_i[7];
          last_d   = tx_last_i;
          csb_d    = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = (state_q == StIdle) ? SetupLd : DivLd;
        end
      end
      StSetup: begin
        if (cnt_done) begin
          cnt_load = 1'b1;
          cnt_val  = DivLd;
        end
      end
      StShift: begin
        if (cnt_done && !sck_q) begin
          sck_d    = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = DivLd;
        end else if (sample) begin
          sck_d  = 1'b0;
          bit_d  = bit_q - 1'b1;
          sreg_d = {sreg_q[6:0], sdo_bit};
          sdi_d  = sreg_q[6];
          if (byte_end) begin
            rx_data_d = {sreg_q[6:0], sdo_bit};
            cnt_load  = last_q;
            cnt_val   = HoldLd;
          end else begin
            cnt_load = 1'b1;
            cnt_val  = DivLd;
          end
        end
      end
      StHold: begin
        if (cnt_done) begin
          csb_d    = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = IdleLd;
        end
      end
      StCsIdle: begin
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    rx_valid_d = rx_valid_q;
    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
    if (byte_end) rx_valid_d = 1'b1;
  end

  // Based on the current state so ready reappears one cycle after
  // entering IDLE, never combinationally from rx_ready_i.
  always_comb begin
    tx_ready_d = ((state_q == StIdle) || (state_q == StGap))
                 && !rx_valid_d && !hs;
  end

  assign tx_ready_o       = tx_ready_q;
  assign rx_valid_o       = rx_valid_q;
  assign rx_data_o        = rx_data_q;
  assign busy_o           = (state_q != StIdle);
  assign spi_device_sck_o = sck_q;
  assign spi_device_csb_o = csb_q;
  assign spi_device_sdi_o = sdi_q;

endmodule

// File: tb/tb_spi_host_driver.sv
// Bench for spi_host_driver: device model echoes bytes, scoreboard
// checks responses, SDI bytes, CSB/SCK timing and reset behaviour.
module tb_spi_host_driver;

  localparam int unsigned ClkDiv   = 2;
  localparam int unsigned CsbSetup = 2;
  localparam int unsigned CsbHold  = 2;
  localparam int unsigned CsbIdle  = 4;

  logic       clk;
  logic       rst_n;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       busy;
  logic       sck;
  logic       csb;
  logic       sdi;
  logic       sdo;
  logic       sdo_en;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_mosi[$];
  logic [7:0] dev_q[$];

  int n_rise = 0;
  int n_csb_rise = 0;
  int low_run = 0, high_run = 0;
  int last_low = 0, last_high = 0;
  int busy_low = 0, last_busy_low = 0;
  logic prev_csb = 1'b1;

  int         dcnt = 0;
  logic [7:0] dev_byte = 8'h00;
  logic [7:0] mosi = 8'h00;

  spi_host_driver #(
    .ClkDiv  (ClkDiv),
    .CsbSetup(CsbSetup),
    .CsbHold (CsbHold),
    .CsbIdle (CsbIdle)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .tx_valid_i         (tx_valid),
    .tx_ready_o         (tx_ready),
    .tx_data_i          (tx_data),
    .tx_last_i          (tx_last),
    .rx_valid_o         (rx_valid),
    .rx_ready_i         (rx_ready),
    .rx_data_o          (rx_data),
    .busy_o             (busy),
    .spi_device_sck_o   (sck),
    .spi_device_csb_o   (csb),
    .spi_device_sdi_o   (sdi),
    .spi_device_sdo_i   (sdo),
    .spi_device_sdo_en_i(sdo_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Device: presents its byte MSB first during each high phase,
  // captures SDI on SCK rise, restarts on CSB rise.
  always @(posedge sck or posedge csb) begin
    if (csb) begin
      dcnt = 0;
    end else begin
      if (dcnt == 0) begin
        if (dev_q.size() > 0) dev_byte = dev_q.pop_front();
        else dev_byte = 8'h00;
      end
      sdo  = dev_byte[7-dcnt];
      mosi = {mosi[6:0], sdi};
      dcnt++;
      if (dcnt == 8) begin
        dcnt = 0;
        if (exp_mosi.size() == 0) chk("sdi_unexpected", 1, 0);
        else chk("sdi_byte", {24'h0, mosi}, {24'h0, exp_mosi.pop_front()});
      end
    end
  end

  always @(posedge sck) n_rise++;

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) chk("rx_unexpected", 1, 0);
      else chk("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
    end
  end

  // CSB / busy run-length tracking.
  always @(negedge clk) begin
    if (!csb) begin
      if (prev_csb) last_high = high_run;
      low_run++;
      high_run = 0;
    end else begin
      if (!prev_csb) begin
        last_low = low_run;
        n_csb_rise++;
      end
      high_run++;
      low_run = 0;
    end
    prev_csb = csb;
    if (!busy) begin
      busy_low++;
    end else if (busy_low > 0) begin
      last_busy_low = busy_low;
      busy_low = 0;
    end
  end

  task automatic send(input logic [7:0] d, input logic l,
                      input logic [7:0] dv, input logic [7:0] ex);
    int n;
    exp_mosi.push_back(d);
    dev_q.push_back(dv);
    exp_rx.push_back(ex);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = l;
    n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) chk("tx_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    tx_last  = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(tx_ready && !busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!(tx_ready && !busy)) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int r0;
    int c0;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    rx_ready = 1'b1;
    sdo      = 1'b0;
    sdo_en   = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_csb", csb, 1);
    chk("rst_sck", sck, 0);
    chk("rst_sdi", sdi, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", tx_ready, 1);

    // Single byte with latency checks.
    send(8'hA5, 1'b1, 8'h3C, 8'h3C);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sck && n < 200);
    chk("first_rise_cycle", n, 1 + CsbSetup + ClkDiv);
    do begin
      @(negedge clk);
      n++;
    end while (!rx_valid && n < 200);
    chk("rx_valid_cycle", n, 1 + CsbSetup + 16 * ClkDiv);
    wait_idle();
    chk("csb_low_len", last_low, CsbSetup + 16 * ClkDiv + CsbHold);

    // Three-byte transaction.
    r0 = n_rise;
    c0 = n_csb_rise;
    send(8'h9F, 1'b0, 8'hEF, 8'hEF);
    send(8'h00, 1'b0, 8'h12, 8'h12);
    send(8'h00, 1'b1, 8'h34, 8'h34);
    wait_idle();
    chk("rises_3byte", n_rise - r0, 24);
    chk("csb_rises_3byte", n_csb_rise - c0, 1);

    // Stall in GAP with response not consumed.
    rx_ready = 1'b0;
    send(8'h55, 1'b0, 8'hA6, 8'hA6);
    n = 0;
    while (!rx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("gap_rx_valid", rx_valid, 1);
    r0 = n_rise;
    repeat (20) @(negedge clk);
    chk("gap_no_sck", n_rise - r0, 0);
    chk("gap_csb_low", csb, 0);
    chk("gap_busy", busy, 1);
    chk("gap_not_ready", tx_ready, 0);
    chk("gap_sck_low", sck, 0);
    rx_ready = 1'b1;
    send(8'hC3, 1'b1, 8'h5A, 8'h5A);
    wait_idle();

    // Released SDO reads as all ones.
    sdo_en = 1'b0;
    send(8'h12, 1'b1, 8'h00, 8'hFF);
    wait_idle();
    sdo_en = 1'b1;

    // Back-to-back single-byte transactions.
    send(8'h81, 1'b1, 8'h7E, 8'h7E);
    send(8'h42, 1'b1, 8'hBD, 8'hBD);
    repeat (2) @(negedge clk);
    chk("csb_idle_gap", last_high, CsbIdle + 2);
    chk("busy_dropped", last_busy_low >= 1, 1);
    wait_idle();

    chk("rx_queue_empty", exp_rx.size(), 0);
    chk("sdi_queue_empty", exp_mosi.size(), 0);

    // Reset in the middle of SHIFT.
    send(8'hF0, 1'b1, 8'h0F, 8'h0F);
    r0 = n_rise;
    n = 0;
    while (n_rise < r0 + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reached_shift", n_rise - r0, 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_csb", csb, 1);
    chk("midrst_sck", sck, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", tx_ready, 0);
    r0 = n_rise;
    repeat (10) @(negedge clk);
    chk("midrst_no_sck", n_rise - r0, 0);
    exp_rx.delete();
    exp_mosi.delete();
    dev_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", tx_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
